// File: rtl/counter4b_cmd_seq_if.sv
// counter4b_cmd_seq_if: command push handshake plus counter drive and status outputs
interface counter4b_cmd_seq_if #(parameter int CNT_W = 8);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_modo;
    logic [3:0]       cmd_d;
    logic [3:0]       cmd_len;
    logic             cmd_clr;
    logic             cnt_enable;
    logic             cnt_reset;
    logic [1:0]       cnt_modo;
    logic [3:0]       cnt_d;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cmd_cnt;
    modport master (
        output cmd_valid, cmd_modo, cmd_d, cmd_len, cmd_clr,
        input  cmd_ready, cnt_enable, cnt_reset, cnt_modo, cnt_d, busy, done, cmd_cnt
    );
    modport slave (
        input  cmd_valid, cmd_modo, cmd_d, cmd_len, cmd_clr,
        output cmd_ready, cnt_enable, cnt_reset, cnt_modo, cnt_d, busy, done, cmd_cnt
    );
endinterface

// File: rtl/counter4b_cmd_seq.sv
// counter4b_cmd_seq: FIFO-fed FSM replaying timed commands onto the 4-bit counter
module counter4b_cmd_seq #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input logic clk,
    input logic reset,
    counter4b_cmd_seq_if.slave s
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] IDLE = 2'd0, CLEAR = 2'd1, RUN = 2'd2;
    logic [10:0]   mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   occ, occ_n;
    logic [1:0]    state, ns;
    logic [3:0]    rem, d_q;
    logic [1:0]    modo_q;
    logic          last_q, fin, pop, push;
    logic [10:0]   head;
    always_comb begin
        head  = mem[rp];
        fin   = state == RUN && rem == 4'd0;
        pop   = (state == IDLE || fin) && occ != '0;
        push  = s.cmd_valid && s.cmd_ready;
        occ_n = occ + (AW+1)'(push) - (AW+1)'(pop);
        ns    = pop ? (head[10] ? CLEAR : RUN) :
                (state == CLEAR || (state == RUN && !fin)) ? RUN : IDLE;
    end
    // outputs trail the FSM state by one register stage
    always_ff @(posedge clk) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
            occ <= '0;
            state <= IDLE;
            rem <= '0;
            modo_q <= '0;
            d_q <= '0;
            last_q <= 1'b0;
            s.cmd_ready <= 1'b0;
            s.cnt_enable <= 1'b0;
            s.cnt_reset <= 1'b0;
            s.cnt_modo <= '0;
            s.cnt_d <= '0;
            s.busy <= 1'b0;
            s.done <= 1'b0;
            s.cmd_cnt <= '0;
        end else begin
            if (push) begin
                mem[wp] <= {s.cmd_clr, s.cmd_len, s.cmd_d, s.cmd_modo};
                wp <= wp + AW'(1);
            end
            if (pop) begin
                rp <= rp + AW'(1);
                rem <= head[9:6];
                d_q <= head[5:2];
                modo_q <= head[1:0];
            end else if (state == RUN && !fin) rem <= rem - 4'd1;
            occ <= occ_n;
            state <= ns;
            last_q <= fin;
            s.cmd_ready <= occ_n != (AW+1)'(DEPTH);
            s.cnt_enable <= state != IDLE;
            s.cnt_reset <= state == CLEAR;
            s.cnt_modo <= state == IDLE ? 2'd0 : modo_q;
            s.cnt_d <= state == IDLE ? 4'd0 : d_q;
            s.busy <= state != IDLE || occ != '0;
            s.done <= last_q;
            s.cmd_cnt <= s.cmd_cnt + CNT_W'(last_q);
        end
    end
endmodule
